// File: rtl/motor_ramp_ctrl_pkg.sv
// Shared definitions for the lift motor ramp controller: state encoding,
// level limits and small helpers used by the controller and its PWM stage.
package motor_ramp_ctrl_pkg;

  localparam int LEVEL_W = 3;

  localparam logic [LEVEL_W-1:0] MAX_LEVEL = 3'd5;
  localparam logic [LEVEL_W-1:0] MIN_LEVEL = 3'd1;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_RAMP_UP   = 3'd1;
  localparam logic [2:0] ST_HOLD      = 3'd2;
  localparam logic [2:0] ST_RAMP_DOWN = 3'd3;
  localparam logic [2:0] ST_STOP      = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE      = ST_IDLE,
    S_RAMP_UP   = ST_RAMP_UP,
    S_HOLD      = ST_HOLD,
    S_RAMP_DOWN = ST_RAMP_DOWN,
    S_STOP      = ST_STOP
  } state_t;

  function automatic logic level_valid(input logic [LEVEL_W-1:0] lvl);
    return (lvl >= MIN_LEVEL) && (lvl <= MAX_LEVEL);
  endfunction

  // Resting state once the drive level has settled on its target.
  function automatic state_t rest_state(input logic [LEVEL_W-1:0] lvl);
    return (lvl == '0) ? S_IDLE : S_HOLD;
  endfunction

endpackage

// File: rtl/motor_ramp_ctrl_pwm.sv
// Free-running PWM counter with a registered comparator; the compare
// threshold is duty*DUTY_STEP, computed wide enough that it never truncates.
module motor_pwm_gen
  import motor_ramp_ctrl_pkg::*;
#(
  parameter int PWM_BITS  = 8,
  parameter int DUTY_STEP = 51
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [LEVEL_W-1:0] duty,
  output logic               pwm_out
);

  localparam int CW = PWM_BITS + LEVEL_W;
  localparam logic [CW-1:0] STEP = CW'(DUTY_STEP);

  logic [PWM_BITS-1:0] cnt;
  logic [CW-1:0]       thresh;

  assign thresh = CW'(duty) * STEP;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      pwm_out <= 1'b0;
    end else begin
      cnt     <= cnt + PWM_BITS'(1);
      pwm_out <= ({{LEVEL_W{1'b0}}, cnt} < thresh);
    end
  end

endmodule

// File: rtl/motor_ramp_ctrl.sv
// Lift motor drive-level controller: steps the applied level toward the
// effective target one level per RAMP_DIV cycles, with emergency stop.
module motor_ramp_ctrl
  import motor_ramp_ctrl_pkg::*;
#(
  parameter int RAMP_DIV  = 1000,
  parameter int DUTY_STEP = 51,
  parameter int PWM_BITS  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [LEVEL_W-1:0] powerlevel,
  input  logic               load_valid,
  input  logic               run,
  input  logic               estop,
  output logic [LEVEL_W-1:0] cur_level,
  output logic               pwm_out,
  output logic               at_target,
  output logic               busy,
  output logic               fault
);

  localparam int TW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(RAMP_DIV - 1);

  state_t             state, state_d;
  logic [LEVEL_W-1:0] tgt, tgt_d, cur_d, eff;
  logic [TW-1:0]      tick, tick_d;
  logic               fault_d, at_target_d;

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    eff         = run ? tgt : '0;
    state_d     = state;
    cur_d       = cur_level;
    tick_d      = '0;
    tgt_d       = tgt;
    fault_d     = fault;

    if (load_valid) begin
      if (level_valid(powerlevel)) tgt_d = powerlevel;
      else                         fault_d = 1'b1;
    end

    case (state)
      S_IDLE, S_HOLD: begin
        if (eff > cur_level)      state_d = S_RAMP_UP;
        else if (eff < cur_level) state_d = S_RAMP_DOWN;
        else                      state_d = rest_state(cur_level);
      end
      S_RAMP_UP: begin
        if (eff < cur_level)       state_d = S_RAMP_DOWN;
        else if (eff == cur_level) state_d = rest_state(cur_level);
        else if (tick == TICK_LAST) begin
          cur_d = cur_level + 3'd1;
          if (cur_level + 3'd1 == eff) state_d = rest_state(eff);
        end else begin
          tick_d = tick + TW'(1);
        end
      end
      S_RAMP_DOWN: begin
        if (eff > cur_level)       state_d = S_RAMP_UP;
        else if (eff == cur_level) state_d = rest_state(cur_level);
        else if (tick == TICK_LAST) begin
          cur_d = cur_level - 3'd1;
          if (cur_level - 3'd1 == eff) state_d = rest_state(eff);
        end else begin
          tick_d = tick + TW'(1);
        end
      end
      S_STOP: begin
        cur_d = '0;
        if (!estop && !run) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cur_d   = '0;
      end
    endcase

    // Emergency stop overrides target loads and any pending step.
    if (estop) begin
      state_d = S_STOP;
      cur_d   = '0;
      tick_d  = '0;
      tgt_d   = tgt;
      fault_d = fault;
    end

    at_target_d = ((state_d == S_IDLE) || (state_d == S_HOLD)) &&
                  (cur_d == (run ? tgt_d : '0));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      tgt       <= '0;
      cur_level <= '0;
      tick      <= '0;
      at_target <= 1'b1;
      fault     <= 1'b0;
    end else begin
      state     <= state_d;
      tgt       <= tgt_d;
      cur_level <= cur_d;
      tick      <= tick_d;
      at_target <= at_target_d;
      fault     <= fault_d;
    end
  end

  assign busy = (state == S_RAMP_UP) || (state == S_RAMP_DOWN);

  // Driven from the next level so an emergency stop silences the PWM on the
  // same edge that zeroes cur_level.
  motor_pwm_gen #(
    .PWM_BITS  (PWM_BITS),
    .DUTY_STEP (DUTY_STEP)
  ) u_pwm (
    .clk     (clk),
    .rst     (rst),
    .duty    (cur_d),
    .pwm_out (pwm_out)
  );

endmodule

// File: tb/tb_motor_ramp_ctrl.sv
// Directed scoreboard bench for motor_ramp_ctrl with RAMP_DIV=4: expected
// values are queued as stimulus is applied and compared as the DUT responds.
module tb_motor_ramp_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] powerlevel;
  logic       load_valid;
  logic       run;
  logic       estop;
  logic [2:0] cur_level;
  logic       pwm_out;
  logic       at_target;
  logic       busy;
  logic       fault;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   n_high;

  always #5 clk = ~clk;

  motor_ramp_ctrl #(
    .RAMP_DIV  (4),
    .DUTY_STEP (51),
    .PWM_BITS  (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .powerlevel (powerlevel),
    .load_valid (load_valid),
    .run        (run),
    .estop      (estop),
    .cur_level  (cur_level),
    .pwm_out    (pwm_out),
    .at_target  (at_target),
    .busy       (busy),
    .fault      (fault)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic check_pop(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL sb_empty: observed %0d with no expectation queued", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) else begin
        errors++;
        $display("FAIL %s: observed %0d expected %0d", e.tag, obs, e.exp);
        $error("%s observed %0d expected %0d", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic strobe(input logic [2:0] lvl);
    powerlevel = lvl;
    load_valid = 1'b1;
    tick(1);
    load_valid = 1'b0;
  endtask

  task automatic count_pwm(output int n);
    n = 0;
    repeat (256) begin
      tick(1);
      n += int'(pwm_out);
    end
  endtask

  initial begin
    rst = 1'b1; powerlevel = '0; load_valid = 1'b0; run = 1'b0; estop = 1'b0;
    tick(2);

    // Reset state
    push("rst_cur", 0); push("rst_pwm", 0); push("rst_at_target", 1);
    push("rst_busy", 0); push("rst_fault", 0);
    check_pop(cur_level); check_pop(pwm_out); check_pop(at_target);
    check_pop(busy); check_pop(fault);
    rst = 1'b0;

    push("pwm_lvl0", 0);
    count_pwm(n_high);
    check_pop(n_high);

    // Ramp up 0 -> 3: steps 4, 8, 12 cycles after entering RAMP_UP
    push("up_busy", 1); push("up_pre_step", 0); push("up_l1", 1);
    push("up_l2", 2); push("up_l3", 3); push("up_at_target", 1); push("up_busy_done", 0);
    run = 1'b1;
    strobe(3'd3);
    tick(1); check_pop(busy);
    tick(3); check_pop(cur_level);
    tick(1); check_pop(cur_level);
    tick(4); check_pop(cur_level);
    tick(4); check_pop(cur_level);
    check_pop(at_target); check_pop(busy);

    // run low: ramp 3 -> 0 and settle in IDLE
    push("dn_busy", 1); push("dn_at_target", 0); push("dn_l2", 2); push("dn_l1", 1);
    push("dn_l0", 0); push("dn_busy_done", 0); push("dn_at_target_idle", 1);
    run = 1'b0;
    tick(1); check_pop(busy); check_pop(at_target);
    tick(4); check_pop(cur_level);
    tick(4); check_pop(cur_level);
    tick(4); check_pop(cur_level); check_pop(busy); check_pop(at_target);

    // Reverse mid-ramp: toward 5, retarget to 1 at level 3
    push("rev_pre_l3", 3); push("rev_busy", 1); push("rev_hold_l3", 3);
    push("rev_cnt_cleared", 3); push("rev_l2", 2); push("rev_l1", 1);
    push("rev_busy_done", 0); push("rev_at_target", 1);
    run = 1'b1;
    strobe(3'd5);
    tick(13); check_pop(cur_level);
    strobe(3'd1);
    tick(1); check_pop(busy); check_pop(cur_level);
    tick(3); check_pop(cur_level);
    tick(1); check_pop(cur_level);
    tick(4); check_pop(cur_level); check_pop(busy); check_pop(at_target);

    // Invalid strobe at HOLD level 2
    push("inv_pre_l2", 2); push("inv_fault", 1); push("inv_cur", 2);
    push("inv_cur_later", 2); push("inv_busy", 0); push("inv_at_target", 1);
    strobe(3'd2);
    tick(5); check_pop(cur_level);
    strobe(3'd7);
    check_pop(fault); check_pop(cur_level);
    tick(6); check_pop(cur_level); check_pop(busy); check_pop(at_target);

    push("pwm_lvl2", 102);
    count_pwm(n_high);
    check_pop(n_high);

    // Level 5 duty and sticky fault
    push("l5_cur", 5); push("l5_at_target", 1); push("l5_fault_sticky", 1); push("pwm_lvl5", 255);
    strobe(3'd5);
    tick(13); check_pop(cur_level); check_pop(at_target); check_pop(fault);
    count_pwm(n_high);
    check_pop(n_high);

    // Emergency stop at level 4, competing with a load strobe
    push("es_pre_l4", 4); push("es_cur", 0); push("es_pwm", 0); push("es_busy", 0);
    push("es_hold_cur", 0); push("es_hold_busy", 0); push("es_hold_at_target", 0);
    push("es_idle_at_target", 1); push("es_idle_cur", 0);
    push("es_tgt_kept_l4", 4); push("es_tgt_kept_at", 1);
    strobe(3'd4);
    tick(5); check_pop(cur_level);
    estop = 1'b1; powerlevel = 3'd5; load_valid = 1'b1;
    tick(1); check_pop(cur_level); check_pop(pwm_out); check_pop(busy);
    load_valid = 1'b0; estop = 1'b0;
    tick(3); check_pop(cur_level); check_pop(busy); check_pop(at_target);
    run = 1'b0;
    tick(1); check_pop(at_target); check_pop(cur_level);
    run = 1'b1;
    tick(20); check_pop(cur_level); check_pop(at_target);

    // Reset in the middle of a ramp down
    push("mr_busy", 1); push("mr_cur", 0); push("mr_busy_rst", 0); push("mr_fault", 0);
    push("mr_cur_after", 0); push("mr_busy_after", 0); push("mr_at_target", 1);
    run = 1'b0;
    tick(3); check_pop(busy);
    rst = 1'b1;
    tick(1); check_pop(cur_level); check_pop(busy); check_pop(fault);
    rst = 1'b0; run = 1'b1;
    tick(8); check_pop(cur_level); check_pop(busy); check_pop(at_target);

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $display("FAIL sb_leftover: observed %0d queued expected 0", sb.size());
      $error("sb_leftover %0d", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/motor_ramp_ctrl.md
MOTOR_RAMP_CTRL -- requirements
Module: motor_ramp_ctrl

Interface
REQ-001 Parameter RAMP_DIV, default 1000: clock cycles per single-level ramp step.
REQ-002 Parameter DUTY_STEP, default 51: PWM compare units per power level.
REQ-003 Parameter PWM_BITS, default 8: PWM counter width.
REQ-004 One clock; reset is synchronous and active-high.
REQ-005 clk  input  1  system clock, all state updates on rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 powerlevel  input  3  target level from the power-saving motor stage; valid 1..5.
REQ-008 load_valid  input  1  one-cycle strobe; samples powerlevel as the new target.
REQ-009 run  input  1  cabin motion request; low commands a ramp to level 0.
REQ-010 estop  input  1  emergency stop, level-sensitive.
REQ-011 cur_level  output  3  motor drive level currently applied, 0..5.
REQ-012 pwm_out  output  1  motor PWM drive.
REQ-013 at_target  output  1  high when cur_level equals the effective target and state is HOLD or IDLE.
REQ-014 busy  output  1  high in RAMP_UP or RAMP_DOWN.
REQ-015 fault  output  1  sticky: an invalid powerlevel was strobed.

Function
REQ-016 Target register tgt (3 bits) SHALL load powerlevel on load_valid when powerlevel is in 1..5; values 0, 6 and 7 SHALL leave tgt unchanged and set fault.
REQ-017 Effective target eff = tgt when run=1, else 0.
REQ-018 FSM states: IDLE (cur_level=0, eff=0), RAMP_UP, HOLD, RAMP_DOWN, STOP.
REQ-019 Transitions from IDLE or HOLD: eff>cur_level -> RAMP_UP; eff<cur_level -> RAMP_DOWN; equal -> HOLD, or IDLE if both are 0.
REQ-020 Ramp tick counter SHALL clear on every entry to RAMP_UP or RAMP_DOWN and on each step. One step (cur_level +/-1) SHALL occur when the counter reaches RAMP_DIV-1, i.e. the first step comes RAMP_DIV cycles after entry.
REQ-021 If a step makes cur_level equal eff, the next state SHALL be HOLD (IDLE if 0).
REQ-022 If eff changes direction mid-ramp, the next cycle SHALL switch to the opposite ramp state with the counter cleared; cur_level is not altered by the change itself.
REQ-023 If eff changes mid-ramp in the same direction, ramping SHALL continue without a counter clear.
REQ-024 If estop=1 in any state, the next cycle SHALL have state STOP and cur_level=0, pwm_out=0 and busy=0; this SHALL take priority over load_valid and ramp steps.
REQ-025 STOP SHALL exit to IDLE only when estop=0 and run=0 in the same cycle.
REQ-026 PWM counter: free-running PWM_BITS wide, wraps 2^PWM_BITS-1 -> 0. pwm_out SHALL be registered, =1 when counter < cur_level*DUTY_STEP, using PWM_BITS+3-bit compare arithmetic with no truncation.
REQ-027 cur_level=0 SHALL give pwm_out constantly 0; level 5 with defaults SHALL give 255 high cycles out of every 256.
REQ-028 cur_level SHALL never exceed 5 or underflow below 0.

Reset
REQ-029 On rst=1 at a clock edge: state IDLE, tgt=0, cur_level=0, tick and PWM counters 0, pwm_out=0, at_target=1, busy=0, fault=0.
REQ-030 Reset mid-ramp SHALL abandon the ramp with no further step, and cur_level SHALL read 0 the cycle after reset.
REQ-031 fault SHALL clear only on reset.

Structure
REQ-032 A shared package SHALL hold the FSM state encoding (3-bit localparams), MAX_LEVEL=5 and MIN_LEVEL=1.
REQ-033 The PWM counter and comparator SHALL be one sub-module, motor_pwm_gen (inputs clk, rst, duty; output pwm_out).
REQ-034 All outputs SHALL be registered or decoded from registered state only.

Verification (RAMP_DIV=4, defaults otherwise)
REQ-035 Reset, then run=1 and strobe powerlevel=3 -> cur_level reads 1, 2, 3 at cycles 4, 8, 12 after entering RAMP_UP; then HOLD with at_target=1 and busy=0.
REQ-036 At HOLD level 3, drop run to 0 -> ramp 3, 2, 1, 0 every 4 cycles, ending in IDLE.
REQ-037 Ramping toward 5, strobe powerlevel=1 at cur_level=3 -> immediate RAMP_DOWN with counter cleared, reaching 1 after 8 cycles.
REQ-038 Strobe powerlevel=7 at HOLD level 2 -> fault=1, tgt stays 2, cur_level stays 2.
REQ-039 Assert estop at cur_level=4 -> cur_level=0 and pwm_out=0 the next cycle. Release estop with run=1 -> stays in STOP; set run=0 -> IDLE.
REQ-040 At cur_level=2 -> pwm_out high for exactly 102 of 256 cycles. At level 5 -> high for 255 of 256 cycles.
